// File: rtl/fifo_v3.sv
// Ring buffer with registered output. A push while full is taken only when a pop frees the slot in the same cycle.
module fifo_v3 #(
  parameter bit           FALL_THROUGH = 1'b0,
  parameter int unsigned  DEPTH        = 4,
  parameter type          dtype        = logic,
  localparam int unsigned CntWidth     = $clog2(DEPTH + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  dtype                data_i,
  input  logic                pop_i,
  output dtype                data_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [CntWidth-1:0] usage_o
);
  localparam int unsigned         PtrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(DEPTH - 1);

  if (FALL_THROUGH) begin : g_bad_mode
    $error("fifo_v3: only FALL_THROUGH=0 is implemented");
  end

  dtype                mem_q [DEPTH];
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] usage_q, usage_d;
  logic                do_push, do_pop;

  assign full_o  = (usage_q == CntWidth'(DEPTH));
  assign empty_o = (usage_q == '0);
  assign usage_o = usage_q;
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  // Output is forced to zero while empty so stale entries never leak after reset.
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    usage_d = usage_q + CntWidth'(do_push) - CntWidth'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usage_q  <= usage_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/fixed_latency_sink.sv
// Credit-throttled sink for a fixed-latency, no-backpressure path; responses are buffered and
// handed downstream on valid/ready. Every issued request owns a buffer slot until its response pops.
module fixed_latency_sink #(
  parameter int unsigned  Depth    = 32'd4,
  parameter type          dtype    = logic,
  localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  output logic                req_valid_o,
  input  logic                rsp_valid_i,
  input  dtype                rsp_data_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output dtype                rsp_data_o,
  output logic [CntWidth-1:0] usage_o,
  output logic                overflow_o
);
  if (Depth == 0) begin : g_bad_depth
    $error("fixed_latency_sink: Depth must be >= 1");
  end

  logic [CntWidth-1:0] credit_q, credit_d;
  logic                overflow_q, overflow_d;
  logic                issue, pop, buf_full, buf_empty, drop;

  assign req_ready_o = (credit_q != '0);
  assign issue       = req_valid_i & req_ready_o;
  assign req_valid_o = issue;
  assign rsp_valid_o = ~buf_empty;
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign drop        = rsp_valid_i & buf_full & ~pop;
  assign overflow_o  = overflow_q;

  assign credit_d   = credit_q - CntWidth'(issue) + CntWidth'(pop);
  assign overflow_d = overflow_q | drop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credit_q   <= CntWidth'(Depth);
      overflow_q <= 1'b0;
    end else begin
      credit_q   <= credit_d;
      overflow_q <= overflow_d;
    end
  end

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DEPTH        (Depth),
    .dtype        (dtype)
  ) u_rsp_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (rsp_valid_i),
    .data_i  (rsp_data_i),
    .pop_i   (rsp_ready_i),
    .data_o  (rsp_data_o),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .usage_o (usage_o)
  );

`ifndef SYNTHESIS
  // A drop means the path produced a response nobody holds a credit for.
  a_no_drop: assert property (@(posedge clk_i) disable iff (!rst_ni) !drop)
    else $warning("fixed_latency_sink: response dropped, buffer full");
  a_credit_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    credit_q <= CntWidth'(Depth))
    else $error("fixed_latency_sink: credit above Depth");
  a_issue_credit: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(req_valid_o && credit_q == '0))
    else $error("fixed_latency_sink: issue without credit");
`endif
endmodule
